// File: rtl/axi_wr_arb_pkg.sv
// axi_wr_arb_pkg
// Shared definitions for the AXI write-port arbiter:
//   - FSM state encoding
//   - constant AW attribute codes driven downstream
//   - round-robin pointer advance helper
package axi_wr_arb_pkg;

  // Arbiter FSM states; encodings are fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_e;

  // Every burst moves 64-bit beats with incrementing addresses.
  localparam logic [2:0] AWSIZE_64B   = 3'b011;
  localparam logic [1:0] AWBURST_INCR = 2'b01;

  // Index of the requester after idx, wrapping at n requesters.
  function automatic int rr_next(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi_wr_arb_rr_pick.sv
// axi_wr_arb_rr_pick
// Combinational cyclic priority select: returns the first asserted request
// at or after ptr, wrapping at NREQ.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IDXW  highest-priority index (always < NREQ)
//   any  out 1     at least one request asserted
//   idx  out IDXW  winning requester index (0 when any=0)
module axi_wr_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // Walk the offsets from ptr in priority order; the first hit wins.
  // Both loops unroll, so every req[] select uses a constant index.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] &&
            (((int'(ptr) + off) == j) || ((int'(ptr) + off - NREQ) == j))) begin
          any = 1'b1;
          idx = IDXW'(j);
        end else begin
          // earlier winner (if any) is kept
        end
      end
    end
  end

endmodule

// File: rtl/axi_wr_arb.sv
// axi_wr_arb
// Round-robin arbiter sharing one AXI write-request port among NREQ store
// requesters. A grant covers one AW handshake plus all W beats through the
// requester's wlast. B responses are steered back in order through an owner
// FIFO that records the granted index at each AW handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_aw* / req_awrdy           per-requester AW channel (packed, req 0 in LSBs)
//   req_w*  / req_wrdy            per-requester W channel
//   req_bvld / req_bresp / req_brdy  per-requester B channel
//   lsu_axi_aw* / axi_lsu_awrdy   downstream AW channel
//   lsu_axi_w*  / axi_lsu_wrdy    downstream W channel
//   axi_lsu_bvld / axi_lsu_bresp / lsu_axi_brdy  downstream B channel
module axi_wr_arb
  import axi_wr_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OUTS = 4,
  parameter int IDXW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_awvld,
  input  logic [NREQ*10-1:0] req_awaddr,
  input  logic [NREQ*8-1:0]  req_awlen,
  input  logic [NREQ*3-1:0]  req_awstr,
  input  logic [NREQ*12-1:0] req_oram_addr,
  output logic [NREQ-1:0]    req_awrdy,
  input  logic [NREQ*64-1:0] req_wdata,
  input  logic [NREQ*8-1:0]  req_wstrb,
  input  logic [NREQ-1:0]    req_wlast,
  input  logic [NREQ-1:0]    req_wvld,
  output logic [NREQ-1:0]    req_wrdy,
  output logic [NREQ-1:0]    req_bvld,
  output logic [NREQ*2-1:0]  req_bresp,
  input  logic [NREQ-1:0]    req_brdy,
  output logic               lsu_axi_awvld,
  output logic [7:0]         lsu_axi_awid,
  output logic [9:0]         lsu_axi_awaddr,
  output logic [7:0]         lsu_axi_awlen,
  output logic [2:0]         lsu_axi_awsize,
  output logic [1:0]         lsu_axi_awburst,
  output logic [2:0]         lsu_axi_awstr,
  output logic [11:0]        lsu_axi_oram_addr,
  input  logic               axi_lsu_awrdy,
  output logic [63:0]        lsu_axi_wdata,
  output logic [7:0]         lsu_axi_wstrb,
  output logic               lsu_axi_wlast,
  output logic               lsu_axi_wvld,
  input  logic               axi_lsu_wrdy,
  input  logic               axi_lsu_bvld,
  input  logic [1:0]         axi_lsu_bresp,
  output logic               lsu_axi_brdy
);

  localparam int PW = $clog2(OUTS);

  state_e          state;
  logic [IDXW-1:0] gnt;
  logic [IDXW-1:0] rr_ptr;

  logic            pick_any;
  logic [IDXW-1:0] pick_idx;

  // Granted-slice views of the requester buses.
  logic        sel_awvld;
  logic [9:0]  sel_awaddr;
  logic [7:0]  sel_awlen;
  logic [2:0]  sel_awstr;
  logic [11:0] sel_oram;
  logic [63:0] sel_wdata;
  logic [7:0]  sel_wstrb;
  logic        sel_wlast;
  logic        sel_wvld;

  // Owner FIFO: one entry per AW accepted but not yet answered on B.
  logic [IDXW-1:0] owner_q [OUTS];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IDXW-1:0] head;

  logic aw_hs;
  logic w_last_hs;
  logic push;
  logic pop;

  axi_wr_arb_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req (req_awvld),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Select the granted requester's AW and W fields.
  always_comb begin
    sel_awvld  = 1'b0;
    sel_awaddr = 10'd0;
    sel_awlen  = 8'd0;
    sel_awstr  = 3'd0;
    sel_oram   = 12'd0;
    sel_wdata  = 64'd0;
    sel_wstrb  = 8'd0;
    sel_wlast  = 1'b0;
    sel_wvld   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDXW'(i)) begin
        sel_awvld  = req_awvld[i];
        sel_awaddr = req_awaddr[i*10 +: 10];
        sel_awlen  = req_awlen[i*8 +: 8];
        sel_awstr  = req_awstr[i*3 +: 3];
        sel_oram   = req_oram_addr[i*12 +: 12];
        sel_wdata  = req_wdata[i*64 +: 64];
        sel_wstrb  = req_wstrb[i*8 +: 8];
        sel_wlast  = req_wlast[i];
        sel_wvld   = req_wvld[i];
      end else begin
        // non-granted slices leave the defaults
      end
    end
  end

  // Downstream AW/W: valids are only exposed in the matching FSM state,
  // so nothing leaks out while IDLE is arbitrating.
  assign lsu_axi_awvld     = (state == ST_AW) && sel_awvld;
  assign lsu_axi_awid      = 8'(gnt);
  assign lsu_axi_awaddr    = sel_awaddr;
  assign lsu_axi_awlen     = sel_awlen;
  assign lsu_axi_awsize    = AWSIZE_64B;
  assign lsu_axi_awburst   = AWBURST_INCR;
  assign lsu_axi_awstr     = sel_awstr;
  assign lsu_axi_oram_addr = sel_oram;
  assign lsu_axi_wdata     = sel_wdata;
  assign lsu_axi_wstrb     = sel_wstrb;
  assign lsu_axi_wlast     = sel_wlast;
  assign lsu_axi_wvld      = (state == ST_W) && sel_wvld;

  assign aw_hs     = lsu_axi_awvld && axi_lsu_awrdy;
  assign w_last_hs = lsu_axi_wvld && axi_lsu_wrdy && sel_wlast;

  // Route downstream readies back to the granted requester only.
  always_comb begin
    req_awrdy = '0;
    req_wrdy  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDXW'(i)) begin
        req_awrdy[i] = (state == ST_AW) && axi_lsu_awrdy;
        req_wrdy[i]  = (state == ST_W) && axi_lsu_wrdy;
      end else begin
        // non-granted requesters stay stalled
      end
    end
  end

  // Arbitration FSM. IDLE registers the winner so there is a full cycle
  // between req_awvld and lsu_axi_awvld; a full owner FIFO holds off grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any && !fifo_full) begin
            gnt   <= pick_idx;
            state <= ST_AW;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            state <= ST_W;
          end else begin
            state <= ST_AW;
          end
        end
        ST_W: begin
          if (w_last_hs) begin
            state  <= ST_IDLE;
            // The requester just served drops to lowest priority.
            rr_ptr <= IDXW'(rr_next(int'(gnt), NREQ));
          end else begin
            state <= ST_W;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_full  = (count == (PW+1)'(OUTS));
  assign fifo_empty = (count == (PW+1)'(0));
  assign head       = owner_q[rd_ptr];
  assign push       = aw_hs;
  assign pop        = axi_lsu_bvld && lsu_axi_brdy;

  // Steer the in-order B response to the FIFO head owner. With the FIFO
  // empty nothing is ready, so a stray response stays visible downstream.
  always_comb begin
    req_bvld     = '0;
    lsu_axi_brdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!fifo_empty && (head == IDXW'(i))) begin
        req_bvld[i]  = axi_lsu_bvld;
        lsu_axi_brdy = req_brdy[i];
      end else begin
        // not the owner of the current response
      end
    end
  end

  assign req_bresp = {NREQ{axi_lsu_bresp}};

  // Owner FIFO storage and pointers. Push and pop in one cycle leave the
  // count unchanged, even when full (the pop frees the slot being written).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUTS; i++) begin
        owner_q[i] <= '0;
      end
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + PW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
